mem_access_unit: RTL
====================

# mem_access_unit

Multi-cycle load/store initiator between the CPU datapath and the word-addressed `dataMemory` array. It accepts one byte-addressed load/store request at a time over a valid/ready handshake and drives the memory's address, writeData, memWrite and memRead pins. Sub-word stores use read-modify-write. Load data is sign- or zero-extended and returned over a valid/ready response channel, together with an error flag for misaligned or out-of-range accesses.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in the attached memory; legal word index is 0..DEPTH-1.

Ports (one clock; reset is synchronous and active-low):
- `CLK` in 1: system clock; all state changes on posedge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request (high only in IDLE).
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal and raises err.
- `req_unsigned` in 1: zero-extend sub-word loads when 1, sign-extend when 0.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; sub-word data is in the low bits.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: access rejected; memory untouched.
- `mem_address` out 32: word index = {2'b00, addr[31:2]}.
- `mem_writeData` out 32: word to write.
- `mem_memWrite` out 1: write strobe; memory commits on negedge.
- `mem_memRead` out 1: read strobe; memory updates readData on the strobe's edge.
- `mem_readData` in 32: memory read data.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request and check it for errors.
  - Error if the access is misaligned (half with addr[0]=1, word with addr[1:0]≠0), `req_size`=11, or addr[31:2] ≥ DEPTH.
  - On error: go to RESP with err=1.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: `mem_memRead`=1 for exactly one cycle. Sample `mem_readData` at the closing posedge.
  - Load: extract the byte/half at the latched addr[1:0], extend it, then go to RESP.
  - Sub-word store: merge `req_wdata` lanes into the sampled word, then go to WR.
- WR: `mem_memWrite`=1 for exactly one cycle with the merged or full word on `mem_writeData`. Then go to RESP.
- RESP: `resp_valid`=1 and outputs held stable until `resp_ready`. Then go to IDLE.
- `mem_memRead` and `mem_memWrite` are 0 in every other state. This guarantees a fresh memRead edge per access.
- `mem_address` holds the latched word index from RD through WR.
- Lane select: byte lane = addr[1:0], bits [8·lane+7:8·lane]; half lane = addr[1], bits [16·addr[1]+15:16·addr[1]].

## Timing
- Reset values: `req_ready`=1 (IDLE), `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_memRead`=0, `mem_memWrite`=0, `mem_address`=0, `mem_writeData`=0.
- Latency from the accept edge to `resp_valid`:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Throughput: one request per latency + 1 cycles minimum (IDLE is re-entered between requests).
- `req_valid` while not in IDLE is ignored. The requester must hold the request until `req_ready`.
- `resp_ready` already high on entry to RESP: exactly one `resp_valid` cycle.
- Reset mid-operation: next state is IDLE, strobes go to 0, and no response is produced. A store whose WR cycle has already passed the negedge has committed in memory; this is expected.
- Simultaneous reset and `req_valid`: reset wins and the request is not accepted.

## Configuration
- `MAU_SUBWORD_EN` defined: byte and half accesses are supported as described above.
- `MAU_SUBWORD_EN` undefined: any `req_size`≠10 returns err=1 in 1 cycle. The read-modify-write path and extension logic are removed, and stores always go IDLE→WR→RESP.

## Test plan
- Word store then load: store 0xDEADBEEF to addr 0x10 → `mem_address`=4 and `mem_memWrite` high for 1 cycle; load from 0x10 → `resp_rdata`=0xDEADBEEF, err=0, latency 2.
- Byte store RMW: word 4 = 0x11223344; store byte 0xAB to 0x12 → RD then WR; word 4 becomes 0x11AB3344, latency 3.
- Extension: word 4 = 0x11AB3344; signed byte load at 0x12 → 0xFFFFFFAB; unsigned → 0x000000AB; signed half load at 0x10 → 0x00003344.
- Errors: word load at 0x13 → err=1 at 1 cycle, no strobes; load at 0x100 with DEPTH=64 → err=1.
- Backpressure: hold `resp_ready`=0 for 5 cycles → `resp_valid` and data stable, `req_ready`=0; release → IDLE next cycle.
- Reset during RD of a load → no `resp_valid`, strobes 0 the next cycle, `req_ready`=1.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory pin bundle for mem_access_unit.
// slave = the unit's view; master = requester plus memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_readData,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_readData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory; latency 1 (error), 2 (load, word store), 3 (sub-word store RMW).
// One request in flight, response held until resp_ready. Define MAU_SUBWORD_EN for byte/half accesses.
module mem_access_unit #(
  parameter int DEPTH = 64
) (
  input logic              CLK,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state;
  logic   req_err;

`ifdef MAU_SUBWORD_EN
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] ln, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] ln);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{ln, 3'b000} +: 8] = d[7:0];
    else             r[{ln[1], 4'b0000} +: 16] = d[15:0];
    return r;
  endfunction
`endif

  always_comb begin
    req_err = 1'b0;
    if ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH)) req_err = 1'b1;
`ifdef MAU_SUBWORD_EN
    case (bus.req_size)
      2'b00:   req_err = req_err;
      2'b01:   if (bus.req_addr[0]) req_err = 1'b1;
      2'b10:   if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
`else
    if (bus.req_size != 2'b10 || bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state             <= IDLE;
      bus.req_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_err      <= 1'b0;
      bus.resp_rdata    <= 32'h0;
      bus.mem_memRead   <= 1'b0;
      bus.mem_memWrite  <= 1'b0;
      bus.mem_address   <= 32'h0;
      bus.mem_writeData <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
`ifdef MAU_SUBWORD_EN
            wr_q    <= bus.req_write;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
`endif
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else begin
              bus.mem_address <= {2'b00, bus.req_addr[31:2]};
              if (bus.req_write && bus.req_size == 2'b10) begin
                state             <= WR;
                bus.mem_memWrite  <= 1'b1;
                bus.mem_writeData <= bus.req_wdata;
              end else begin
                state           <= RD;
                bus.mem_memRead <= 1'b1;
              end
            end
          end
        end
        RD: begin
          bus.mem_memRead <= 1'b0;
`ifdef MAU_SUBWORD_EN
          if (wr_q) begin
            // sub-word store: splice new lanes into the word just read
            state             <= WR;
            bus.mem_memWrite  <= 1'b1;
            bus.mem_writeData <= store_merge(bus.mem_readData, wdata_q, size_q, lane_q);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_ext(bus.mem_readData, size_q, lane_q, uns_q);
          end
`else
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= bus.mem_readData;
`endif
        end
        WR: begin
          bus.mem_memWrite <= 1'b0;
          state            <= RESP;
          bus.resp_valid   <= 1'b1;
          bus.resp_rdata   <= 32'h0;
        end
        default: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.req_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
